// File: rtl/pipe_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_scheduler_if
//  Brief    : Control/status bundle between the game front end and the
//             pipe scheduler (tick, button, collision, PRNG in; state,
//             pipe pool and score out).
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_scheduler_if #(
    parameter int NUM_PIPES = 3,
    parameter int SCORE_W   = 8
) ();
    logic                     tick;
    logic                     start_button;
    logic                     collided;
    logic [9:0]               rand_y;
    logic [1:0]               state;
    logic [NUM_PIPES-1:0]     pipe_active;
    logic [10*NUM_PIPES-1:0]  pipe_x;
    logic [10*NUM_PIPES-1:0]  pipe_y;
    logic [SCORE_W-1:0]       score;
    logic                     score_pulse;

    modport master (
        output tick, start_button, collided, rand_y,
        input  state, pipe_active, pipe_x, pipe_y, score, score_pulse
    );

    modport slave (
        input  tick, start_button, collided, rand_y,
        output state, pipe_active, pipe_x, pipe_y, score, score_pulse
    );
endinterface
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_scheduler
//  Brief    : Play/game-over sequencer owning a pool of obstacle pipe slots.
//             Spawns, advances, retires and scores pipes on each frame tick.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_scheduler #(
    parameter int NUM_PIPES      = 3,
    parameter int PIPE_SPEED     = 4,
    parameter int SPAWN_INTERVAL = 60,
    parameter int PIPE_X_START   = 640,
    parameter int PIPE_WIDTH     = 40,
    parameter int BIRD_X         = 100,
    parameter int PIPE_GAP       = 100,
    parameter int SCORE_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    pipe_scheduler_if.slave   bus
);

    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_play = 2'b01;
    localparam logic [1:0] c_st_over = 2'b10;

    localparam logic [9:0]         c_x_start = 10'(PIPE_X_START);
    localparam logic [9:0]         c_speed   = 10'(PIPE_SPEED);
    localparam logic [10:0]        c_width   = 11'(PIPE_WIDTH);
    localparam logic [10:0]        c_bird_x  = 11'(BIRD_X);
    localparam logic [9:0]         c_y_min   = 10'(PIPE_GAP);
    localparam logic [9:0]         c_y_max   = 10'(479 - PIPE_GAP);
    localparam logic [CNT_W-1:0]   c_reload  = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [SCORE_W+3:0] c_score_max = {4'b0000, {SCORE_W{1'b1}}};

    logic [1:0]                  r_state;
    logic                        r_start_q;
    logic [NUM_PIPES-1:0]        r_active;
    logic [NUM_PIPES-1:0]        r_scored;
    logic [NUM_PIPES-1:0][9:0]   r_x;
    logic [NUM_PIPES-1:0][9:0]   r_y;
    logic [SCORE_W-1:0]          r_score;
    logic                        r_score_pulse;
    logic [CNT_W-1:0]            r_spawn_cnt;

    logic                        w_start_edge;
    logic [9:0]                  w_y_clamp;
    logic [NUM_PIPES-1:0]        w_active_nx;
    logic [NUM_PIPES-1:0]        w_scored_nx;
    logic [NUM_PIPES-1:0][9:0]   w_x_nx;
    logic [NUM_PIPES-1:0][9:0]   w_y_nx;
    logic [3:0]                  w_hits;
    logic                        w_spawned;
    logic [SCORE_W+3:0]          w_score_sum;
    logic [SCORE_W-1:0]          w_score_nx;

    assign w_start_edge = bus.start_button & ~r_start_q;

    assign w_y_clamp = (bus.rand_y < c_y_min) ? c_y_min :
                       (bus.rand_y > c_y_max) ? c_y_max : bus.rand_y;

    // Next-state of the pipe pool for one PLAY tick: move/retire, score, spawn.
    always_comb begin
        w_active_nx = r_active;
        w_scored_nx = r_scored;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_hits      = 4'd0;
        w_spawned   = 1'b0;

        for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_active[i]) begin
                if (r_x[i] <= c_speed) begin
                    w_active_nx[i] = 1'b0;
                    w_scored_nx[i] = 1'b0;
                    w_x_nx[i]      = c_x_start;
                    w_y_nx[i]      = 10'd0;
                end else begin
                    w_x_nx[i] = r_x[i] - c_speed;
                    if (!r_scored[i] && (({1'b0, w_x_nx[i]} + c_width) < c_bird_x)) begin
                        w_scored_nx[i] = 1'b1;
                        w_hits         = w_hits + 4'd1;
                    end
                end
            end
        end

        // Only slots that were already free before this tick are eligible,
        // so a slot retired on this tick waits for the next one.
        if (r_spawn_cnt == '0) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (!r_active[i] && !w_spawned) begin
                    w_spawned      = 1'b1;
                    w_active_nx[i] = 1'b1;
                    w_scored_nx[i] = 1'b0;
                    w_x_nx[i]      = c_x_start;
                    w_y_nx[i]      = w_y_clamp;
                end
            end
        end

        w_score_sum = {4'b0000, r_score} + {{SCORE_W{1'b0}}, w_hits};
        w_score_nx  = (w_score_sum > c_score_max) ? {SCORE_W{1'b1}}
                                                  : w_score_sum[SCORE_W-1:0];
    end

    // Game state machine and registered pool/score update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_start_q     <= 1'b1;
            r_active      <= '0;
            r_scored      <= '0;
            r_x           <= {NUM_PIPES{c_x_start}};
            r_y           <= '0;
            r_score       <= '0;
            r_score_pulse <= 1'b0;
            r_spawn_cnt   <= '0;
        end else begin
            r_start_q     <= bus.start_button;
            r_score_pulse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start_edge) begin
                        r_state     <= c_st_play;
                        r_active    <= '0;
                        r_scored    <= '0;
                        r_x         <= {NUM_PIPES{c_x_start}};
                        r_y         <= '0;
                        r_score     <= '0;
                        r_spawn_cnt <= '0;
                    end
                end
                c_st_play: begin
                    // A collision discards any tick in the same cycle.
                    if (bus.collided) begin
                        r_state <= c_st_over;
                    end else if (bus.tick) begin
                        r_active      <= w_active_nx;
                        r_scored      <= w_scored_nx;
                        r_x           <= w_x_nx;
                        r_y           <= w_y_nx;
                        r_score       <= w_score_nx;
                        r_score_pulse <= (w_hits != 4'd0);
                        r_spawn_cnt   <= (r_spawn_cnt == '0) ? c_reload
                                                             : r_spawn_cnt - CNT_W'(1);
                    end
                end
                c_st_over: begin
                    if (w_start_edge) begin
                        r_state  <= c_st_idle;
                        r_active <= '0;
                        r_scored <= '0;
                        r_x      <= {NUM_PIPES{c_x_start}};
                        r_y      <= '0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.state       = r_state;
    assign bus.pipe_active = r_active;
    assign bus.pipe_x      = r_x;
    assign bus.pipe_y      = r_y;
    assign bus.score       = r_score;
    assign bus.score_pulse = r_score_pulse;

endmodule
`default_nettype wire

// File: doc/pipe_scheduler.md
# pipe_scheduler

Game-sequencing controller that owns the play/game-over state machine and a pool of obstacle pipe slots. It spawns, advances, retires and scores pipes on each frame tick. It replaces the single-pipe, tick-clocked position logic with a fully synchronous, multi-pipe scheduler. It sits between the frame-tick generator, PRNG and collision checker upstream and the renderer and score display downstream.

## Interface
- NUM_PIPES, 3, number of pipe slots in the pool (1..8)
- PIPE_SPEED, 4, pixels subtracted from each active pipe x per tick
- SPAWN_INTERVAL, 60, ticks between spawn attempts (≥1)
- PIPE_X_START, 640, x loaded into a newly spawned pipe
- PIPE_WIDTH, 40, pipe width in pixels, used for scoring
- BIRD_X, 100, bird x position
- PIPE_GAP, 100, half gap height; spawn y is clamped to [PIPE_GAP, 479-PIPE_GAP]
- SCORE_W, 8, score width
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame-advance strobe
- start_button  in  1  level input; only its rising edge acts
- collided  in  1  collision flag from collision checker
- rand_y  in  10  PRNG sample, read at spawn
- state  out  2  00 IDLE, 01 PLAY, 10 GAME_OVER
- pipe_active  out  NUM_PIPES  per-slot valid
- pipe_x  out  10*NUM_PIPES  slot i at bits [10i+9:10i]
- pipe_y  out  10*NUM_PIPES  gap centre per slot, same packing
- score  out  SCORE_W  pipes passed, saturating
- score_pulse  out  1  one-cycle pulse on each score increment

## Operation
- start_edge = start_button & ~start_q. start_q is a register of start_button.
- IDLE → PLAY on start_edge. Entry clears all slots, sets score=0, and sets spawn_cnt=0, so the first tick spawns.
- PLAY → GAME_OVER when collided=1 (any cycle). GAME_OVER → IDLE on start_edge. IDLE entry clears all slots and keeps score.
- Ticks are ignored outside PLAY. In GAME_OVER, positions, active flags and score are frozen.
- On tick in PLAY with collided=0, the following happen in one update:
  - Move: each active slot with x_old ≤ PIPE_SPEED is retired: active←0, scored←0. Every other active slot gets x←x_old−PIPE_SPEED.
  - Score: for a moved slot with scored=0 and x_new+PIPE_WIDTH < BIRD_X (11-bit compare), set scored←1. Increment score by 1, saturating at 2^SCORE_W−1, and assert score_pulse. If more than one slot qualifies in one tick, the score still rises by 1 per slot, saturating.
  - Spawn: if spawn_cnt=0, allocate the lowest-index slot that was inactive before this tick. Set x=PIPE_X_START, y=clamp(rand_y), scored=0. Reload spawn_cnt=SPAWN_INTERVAL−1. Otherwise spawn_cnt decrements.
  - A slot retired this tick is not reused until the next tick.
  - If no slot is free, the spawn is dropped and the counter still reloads.
  - A spawned slot does not move on its spawn tick.
- collided and tick in the same cycle: collided wins. The state goes to GAME_OVER and the tick is discarded, so there is no move, spawn or score.
- Inactive slots drive x=PIPE_X_START and y=0.

## Timing
- All outputs are registered. An event sampled at edge n is visible after edge n, with 1-cycle latency.
- The state changes on the edge that samples its condition.
- score_pulse is high for exactly the cycle after the scoring tick.
- Reset values: state=IDLE, pipe_active=0, all pipe_x=PIPE_X_START, all pipe_y=0, score=0, score_pulse=0, spawn_cnt=0.
- start_q resets to 1, so a button held through reset does not start a game.
- Reset is sampled on clk only. Reset in any state, including mid-tick, overrides all other inputs that cycle.

## Test plan
- **Start and first spawn:** reset, then start rising edge, then a tick with rand_y=300.
  - Required: state=01 one cycle after the edge, slot0 active with x=640 and y=300.
  - Repeat with rand_y=20 → y=100, and with rand_y=450 → y=379.
- **Motion and spacing:** 60 ticks after the first spawn.
  - Required: slot1 spawns at x=640 while slot0 x=400.
  - Ticks while state≠01 change nothing.
- **Scoring:** run until slot0 x_new=56 (tick 146 after spawn).
  - Required: score 0→1 and score_pulse high for exactly one cycle.
  - No further increment for that slot. With the score preloaded near 255 by long play, the score holds at 255.
- **Retire and reuse:** with a slot at x=4, a tick retires it (pipe_active bit →0).
  - With SPAWN_INTERVAL=20, all 3 slots fill; the 4th attempt is dropped; the next spawn uses the lowest freed index.
- **Collision priority:** collided=1 and tick in the same cycle.
  - Required: state=10 and all x unchanged. Later ticks change nothing.
  - A start edge goes to IDLE with slots cleared and score kept. A second edge goes to PLAY with score=0.
- **Reset mid-play:** one-cycle reset during PLAY with 2 active slots.
  - Required: all reset values on the next edge. A held start_button does not restart until it is released and pressed again.
